onehot_low_capture_encoder: RTL and testbench
=============================================

// Module: onehot_low_capture_encoder
// PURPOSE
//  Consumes the 8-bit active-low one-hot vector from the 3-to-8 decoder stage ({Y7..Y0}).
//  Classifies each beat as clean, none or multi, and encodes it to a 3-bit index.
//  Buffers results in a 2-entry FIFO with a valid/ready handshake on both sides.
//  Keeps a saturating error counter so repaired decoders can be checked sequentially.
// PARAMETERS
//  CNT_W      8  width of the error counter (and of each hit counter when enabled)
//  DROP_NONE  0  1: all-high (disabled decoder) beats are accepted but not enqueued
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  y_n        in   8      decoder outputs, bit i = Yi, active low
//  in_valid   in   1      y_n is valid this cycle
//  in_ready   out  1      stage can accept a beat (FIFO not full)
//  out_valid  out  1      FIFO head is valid
//  out_ready  in   1      consumer takes the head
//  out_idx    out  3      encoded index of the head entry
//  out_none   out  1      head beat was all-high (8'hFF)
//  out_err    out  1      head beat had more than one low bit
//  clear      in   1      synchronous clear of all counters
//  err_cnt    out  CNT_W  number of accepted multi-low beats, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async): FIFO empty, out_valid=0, in_ready=1, out_idx=0,
//    out_none=0, out_err=0, err_cnt=0. Reset mid-transfer discards all entries.
//  - Accept = in_valid & in_ready; pop = out_valid & out_ready.
//  - Classification of y_n:
//    exactly one low bit: idx = position of that bit, none=0, err=0 (clean).
//    8'hFF: idx=0, none=1, err=0.
//    two or more low bits: idx = lowest low position, none=0, err=1.
//  - Latency: a beat accepted in cycle N is at the head with out_valid=1 in cycle N+1
//    when the FIFO was empty. No combinational path from in_* to out_*.
//  - FIFO state machine, count in {EMPTY, ONE, FULL}:
//    EMPTY: accept -> ONE.
//    ONE:   accept only -> FULL; pop only -> EMPTY; accept and pop together -> ONE.
//    FULL:  pop -> ONE. in_ready=0, so no accept is possible.
//  - in_ready = (state != FULL) and is registered.
//  - Head entry and out_* stay stable while out_valid=1 and out_ready=0.
//  - DROP_NONE=1: a none beat is accepted (in_ready rules unchanged) and the FIFO
//    state does not change.
//  - err_cnt increments on each accepted err beat and holds at 2^CNT_W-1.
//    clear=1 forces 0; clear wins over a same-cycle increment.
//  - Classification and counting happen at accept time, not at pop.
// CONFIGURATION
//  - Macro ONEHOT_ENC_HIT_COUNT_EN defined: adds output hit_cnt [8*CNT_W-1:0].
//    Slice i counts accepted clean beats with idx=i; same saturation and clear rules.
//  - Macro undefined: port hit_cnt and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package onehot_enc_pkg: N_LINES=8, IDX_W=3, and typedef struct packed entry_t {idx, none, err}.
//  - The classifier is in-line combinational logic.
//  - Sub-module onehot_enc_fifo2: 2-entry entry_t FIFO holding the state machine and
//    both handshakes.
// TESTING
//  1. Reset, then y_n=8'hFB with out_ready=1 -> next cycle out_valid=1,
//     out_idx=2, out_err=0, out_none=0.
//  2. y_n=8'hFF -> out_none=1, out_idx=0; with DROP_NONE=1 -> out_valid stays 0.
//  3. y_n=8'hF5 -> out_err=1, out_idx=1, err_cnt 0->1.
//     Then clear together with a second err beat -> err_cnt=0.
//  4. out_ready=0 and three beats 8'hFE, 8'hFD, 8'hF7 offered back-to-back ->
//     in_ready=0 after two accepts. Pops return idx 0, then 1, then 3 once accepted.
//  5. CNT_W=2, five err beats -> err_cnt saturates at 3.
//     With ONEHOT_ENC_HIT_COUNT_EN: 8'h7F twice -> hit_cnt slice 7 = 2.
//  6. rst_n pulsed low while FULL -> out_valid=0, in_ready=1 immediately, counters 0.

Source files
------------

// File: rtl/onehot_enc_pkg.sv
// Shared types for the active-low one-hot capture encoder: line/index widths,
// the queued entry format and the FIFO occupancy states.
package onehot_enc_pkg;

    localparam int N_LINES = 8;
    localparam int IDX_W   = 3;

    // One classified decoder beat as it sits in the FIFO.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             none;
        logic             err;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/onehot_enc_fifo2.sv
// Two-entry entry_t FIFO with valid/ready on both sides and a registered in_ready.
// The occupancy state machine is exported on state_o for observation.
module onehot_enc_fifo2
    import onehot_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  entry_t      in_data,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output entry_t      out_data,
    output fifo_state_e state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; the producer holds data while valid=1 and ready=0.
    fifo_state_e state_q, state_d;
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    logic        in_ready_q, in_ready_d;
    logic        push, pop;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_ONE;
                    head_d  = in_data;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = in_data;
                end else if (push) begin
                    state_d = ST_FULL;
                    tail_d  = in_data;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the pop can occur.
                if (pop) begin
                    state_d = ST_ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = head_q;
    assign state_o   = state_q;

endmodule

// File: rtl/onehot_low_capture_encoder.sv
// Classifies active-low one-hot decoder beats, queues them in a 2-entry FIFO and
// counts multi-low beats. Define ONEHOT_ENC_HIT_COUNT_EN to add per-line hit counters.
module onehot_low_capture_encoder
    import onehot_enc_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter bit DROP_NONE = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LINES-1:0] y_n,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_none,
    output logic               out_err,
    input  logic               clear,
    output logic [CNT_W-1:0]   err_cnt
`ifdef ONEHOT_ENC_HIT_COUNT_EN
    ,
    output logic [N_LINES*CNT_W-1:0] hit_cnt
`endif
);

    entry_t      cls;
    entry_t      head;
    fifo_state_e fifo_state;
    logic [3:0]  n_low;
    logic        accept;
    logic        drop;
    logic        fifo_in_valid;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Scan from the top so the lowest low position is the one left in idx.
    always_comb begin
        cls   = '0;
        n_low = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (!y_n[i]) begin
                cls.idx = IDX_W'(i);
                n_low   = n_low + 4'd1;
            end
        end
        cls.none = (n_low == 4'd0);
        cls.err  = (n_low > 4'd1);
    end

    assign accept        = in_valid & in_ready;
    assign drop          = DROP_NONE & cls.none;
    assign fifo_in_valid = in_valid & ~drop;

    onehot_enc_fifo2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fifo_in_valid),
        .in_data   (cls),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head),
        .state_o   (fifo_state)
    );

    // An empty FIFO presents zeros rather than the stale head register.
    always_comb begin
        out_idx  = '0;
        out_none = 1'b0;
        out_err  = 1'b0;
        if (fifo_state != ST_EMPTY) begin
            out_idx  = head.idx;
            out_none = head.none;
            out_err  = head.err;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear) begin
            err_cnt_d = '0;
        end else if (accept && cls.err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

`ifdef ONEHOT_ENC_HIT_COUNT_EN
    logic [N_LINES-1:0][CNT_W-1:0] hit_q, hit_d;

    always_comb begin
        hit_d = hit_q;
        for (int i = 0; i < N_LINES; i++) begin
            if (clear) begin
                hit_d[i] = '0;
            end else if (accept && !cls.none && !cls.err &&
                         (cls.idx == IDX_W'(i)) && (hit_q[i] != '1)) begin
                hit_d[i] = hit_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_cnt = hit_q;
`endif

endmodule

// File: tb/tb_onehot_low_capture_encoder.sv
// Bench for onehot_low_capture_encoder: a default instance (CNT_W=8) and a
// CNT_W=2, DROP_NONE=1 instance share stimulus and are checked against a queue model.
module tb_onehot_low_capture_encoder;

    localparam int CNT_A = 8;
    localparam int CNT_B = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] y_n = 8'hFF;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       clear = 1'b0;

    logic             a_in_ready, a_out_valid, a_out_none, a_out_err;
    logic [2:0]       a_out_idx;
    logic [CNT_A-1:0] a_err_cnt;
    logic             b_in_ready, b_out_valid, b_out_none, b_out_err;
    logic [2:0]       b_out_idx;
    logic [CNT_B-1:0] b_err_cnt;
`ifdef ONEHOT_ENC_HIT_COUNT_EN
    logic [8*CNT_A-1:0] a_hit;
    logic [8*CNT_B-1:0] b_hit;
`endif

    // Model: each queue entry is {idx[2:0], none, err}.
    logic [4:0] qa[$];
    logic [4:0] qb[$];
    int         err_a, err_b;
    int         hit_a[8];
    int         hit_b[8];
    bit         acc_a, acc_b;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    onehot_low_capture_encoder #(.CNT_W(CNT_A), .DROP_NONE(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .y_n(y_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_idx(a_out_idx),
        .out_none(a_out_none), .out_err(a_out_err), .clear(clear), .err_cnt(a_err_cnt)
`ifdef ONEHOT_ENC_HIT_COUNT_EN
        , .hit_cnt(a_hit)
`endif
    );

    onehot_low_capture_encoder #(.CNT_W(CNT_B), .DROP_NONE(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .y_n(y_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_idx(b_out_idx),
        .out_none(b_out_none), .out_err(b_out_err), .clear(clear), .err_cnt(b_err_cnt)
`ifdef ONEHOT_ENC_HIT_COUNT_EN
        , .hit_cnt(b_hit)
`endif
    );

    function automatic logic [4:0] ref_class(input logic [7:0] y);
        logic [7:0]  low;
        logic [7:0]  lsb;
        int unsigned n;
        logic [2:0]  idx;
        low = ~y;
        n   = $countones(low);
        lsb = low & (~low + 8'd1);
        idx = 3'd0;
        for (int i = 0; i < 8; i++) if (lsb[i]) idx = 3'(i);
        if (n == 0) return 5'b000_1_0;
        return {idx, 1'b0, (n > 1)};
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        err_a = 0;
        err_b = 0;
        for (int i = 0; i < 8; i++) begin
            hit_a[i] = 0;
            hit_b[i] = 0;
        end
    endtask

    // Advance the model by the coming rising edge using the inputs now driven.
    task automatic model_step();
        logic [4:0] e;
        bit         pop_a, pop_b, clean;
        e     = ref_class(y_n);
        clean = !e[1] && !e[0];
        acc_a = in_valid && (qa.size() < 2);
        acc_b = in_valid && (qb.size() < 2);
        pop_a = (qa.size() > 0) && out_ready;
        pop_b = (qb.size() > 0) && out_ready;
        if (pop_a) void'(qa.pop_front());
        if (pop_b) void'(qb.pop_front());
        if (acc_a) qa.push_back(e);
        if (acc_b && !e[1]) qb.push_back(e);
        if (clear) begin
            err_a = 0;
            err_b = 0;
            for (int i = 0; i < 8; i++) begin
                hit_a[i] = 0;
                hit_b[i] = 0;
            end
        end else begin
            if (acc_a && e[0] && err_a < 255) err_a++;
            if (acc_b && e[0] && err_b < 3) err_b++;
            if (acc_a && clean && hit_a[e[4:2]] < 255) hit_a[e[4:2]]++;
            if (acc_b && clean && hit_b[e[4:2]] < 3) hit_b[e[4:2]]++;
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({a_in_ready, a_out_valid, a_out_idx, a_out_none, a_out_err} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_a_outs: got %b expected 1000000",
                     {a_in_ready, a_out_valid, a_out_idx, a_out_none, a_out_err});
        end
        checks++;
        if ({b_in_ready, b_out_valid, b_out_idx, b_out_none, b_out_err} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_b_outs: got %b expected 1000000",
                     {b_in_ready, b_out_valid, b_out_idx, b_out_none, b_out_err});
        end
        checks++;
        if (a_err_cnt !== 8'd0 || b_err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", a_err_cnt, b_err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_clean();
        y_n = 8'hFB; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({a_out_valid, a_out_idx, a_out_err, a_out_none} !== {1'b1, 3'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clean_a: got v%b i%0d e%b n%b expected v1 i2 e0 n0",
                     a_out_valid, a_out_idx, a_out_err, a_out_none);
        end
        checks++;
        if ({b_out_valid, b_out_idx} !== {1'b1, 3'd2}) begin
            errors++;
            $display("FAIL clean_b: got v%b i%0d expected v1 i2", b_out_valid, b_out_idx);
        end
    endtask

    task automatic test_none();
        y_n = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({a_out_valid, a_out_none, a_out_idx, a_out_err} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL none_a: got v%b n%b i%0d e%b expected v1 n1 i0 e0",
                     a_out_valid, a_out_none, a_out_idx, a_out_err);
        end
        checks++;
        if (b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL none_dropped_b: got out_valid %b expected 0", b_out_valid);
        end
        drain();
    endtask

    task automatic test_err_clear();
        y_n = 8'hF5; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({a_out_err, a_out_idx, a_out_none} !== {1'b1, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL err_head: got e%b i%0d n%b expected e1 i1 n0",
                     a_out_err, a_out_idx, a_out_none);
        end
        checks++;
        if (a_err_cnt !== 8'd1 || b_err_cnt !== 2'd1) begin
            errors++;
            $display("FAIL err_cnt_inc: got %0d/%0d expected 1/1", a_err_cnt, b_err_cnt);
        end
        y_n = 8'hF5; in_valid = 1'b1; clear = 1'b1;
        tick();
        in_valid = 1'b0; clear = 1'b0;
        checks++;
        if (a_err_cnt !== 8'd0 || b_err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL clear_wins: got %0d/%0d expected 0/0", a_err_cnt, b_err_cnt);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0] beats[3];
        logic [2:0] exp_idx[3];
        logic [2:0] got[$];
        int         k;
        beats   = '{8'hFE, 8'hFD, 8'hF7};
        exp_idx = '{3'd0, 3'd1, 3'd3};
        k = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 10 && k < 2; c++) begin
            y_n = beats[k]; in_valid = 1'b1;
            tick();
            if (acc_a) k++;
        end
        checks++;
        if (k != 2 || a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: got accepts %0d in_ready %b/%b expected 2 0/0",
                     k, a_in_ready, b_in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            y_n = beats[2]; in_valid = 1'b1;
            tick();
            checks++;
            if ({a_in_ready, a_out_valid, a_out_idx} !== {1'b0, 1'b1, 3'd0}) begin
                errors++;
                $display("FAIL b2b_hold: got r%b v%b i%0d expected r0 v1 i0",
                         a_in_ready, a_out_valid, a_out_idx);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            if (k < 3) begin
                y_n = beats[k]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (a_out_valid) got.push_back(a_out_idx);
            tick();
            if (acc_a) k++;
        end
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (j >= got.size() || got[j] !== exp_idx[j]) begin
                errors++;
                $display("FAIL b2b_pop%0d: got %0d expected %0d", j,
                         (j < got.size()) ? int'(got[j]) : -1, exp_idx[j]);
            end
        end
        drain();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            y_n = (i % 2 == 0) ? 8'h00 : 8'hF5; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (b_err_cnt !== 2'd3) begin
            errors++;
            $display("FAIL sat_b: got %0d expected 3", b_err_cnt);
        end
        checks++;
        if (a_err_cnt !== 8'd5 || a_err_cnt !== 8'(err_a)) begin
            errors++;
            $display("FAIL sat_a: got %0d expected 5 (model %0d)", a_err_cnt, err_a);
        end
`ifdef ONEHOT_ENC_HIT_COUNT_EN
        for (int i = 0; i < 2; i++) begin
            y_n = 8'h7F; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (a_hit[7*CNT_A +: CNT_A] !== 8'd2 || b_hit[7*CNT_B +: CNT_B] !== 2'd2) begin
            errors++;
            $display("FAIL hit7: got %0d/%0d expected 2/2",
                     a_hit[7*CNT_A +: CNT_A], b_hit[7*CNT_B +: CNT_B]);
        end
`endif
        drain();
    endtask

    task automatic test_random();
        logic [4:0] ha, hb;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0:       y_n = ~(8'd1 << $urandom_range(0, 7));
                1:       y_n = 8'hFF;
                default: y_n = 8'($urandom_range(0, 255));
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 31) == 0);
            tick();
            ha = (qa.size() != 0) ? qa[0] : 5'd0;
            hb = (qb.size() != 0) ? qb[0] : 5'd0;
            checks++;
            if ({a_in_ready, a_out_valid, a_out_idx, a_out_none, a_out_err, a_err_cnt} !==
                {qa.size() < 2, qa.size() > 0, ha, 8'(err_a)}) begin
                errors++;
                $display("FAIL rand_a cyc %0d: got %h expected %h", c,
                         {a_in_ready, a_out_valid, a_out_idx, a_out_none, a_out_err, a_err_cnt},
                         {qa.size() < 2, qa.size() > 0, ha, 8'(err_a)});
            end
            checks++;
            if ({b_in_ready, b_out_valid, b_out_idx, b_out_none, b_out_err, b_err_cnt} !==
                {qb.size() < 2, qb.size() > 0, hb, 2'(err_b)}) begin
                errors++;
                $display("FAIL rand_b cyc %0d: got %h expected %h", c,
                         {b_in_ready, b_out_valid, b_out_idx, b_out_none, b_out_err, b_err_cnt},
                         {qb.size() < 2, qb.size() > 0, hb, 2'(err_b)});
            end
`ifdef ONEHOT_ENC_HIT_COUNT_EN
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (a_hit[i*CNT_A +: CNT_A] !== 8'(hit_a[i]) ||
                    b_hit[i*CNT_B +: CNT_B] !== 2'(hit_b[i])) begin
                    errors++;
                    $display("FAIL rand_hit%0d cyc %0d: got %0d/%0d expected %0d/%0d", i, c,
                             a_hit[i*CNT_A +: CNT_A], b_hit[i*CNT_B +: CNT_B],
                             hit_a[i], hit_b[i]);
                end
            end
`endif
        end
        clear = 1'b0;
        drain();
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        for (int c = 0; c < 6 && qa.size() < 2; c++) begin
            y_n = 8'hF5; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (a_in_ready !== 1'b0 || a_err_cnt === 8'd0) begin
            errors++;
            $display("FAIL pre_reset_full: got in_ready %b err_cnt %0d expected 0 and nonzero",
                     a_in_ready, a_err_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_out_valid, a_in_ready, a_err_cnt, b_out_valid, b_in_ready, b_err_cnt} !==
            {1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL async_reset: got a v%b r%b c%0d b v%b r%b c%0d expected v0 r1 c0",
                     a_out_valid, a_in_ready, a_err_cnt, b_out_valid, b_in_ready, b_err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        y_n = 8'hFB; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({a_out_valid, a_out_idx} !== {1'b1, 3'd2} || qa.size() != 1) begin
            errors++;
            $display("FAIL post_reset_beat: got v%b i%0d expected v1 i2", a_out_valid, a_out_idx);
        end
        drain();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean();
        test_none();
        test_err_clear();
        test_back_to_back();
        test_saturation();
        test_random();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
